// File: rtl/laser_seq_pkg.sv
// laser_seq_pkg
// Shared definitions for the laser pulse sequencer: operating-mode encodings,
// the sequencer state type and the default synchroniser depth.
package laser_seq_pkg;

  localparam logic [1:0] MODE_EXT  = 2'd0;
  localparam logic [1:0] MODE_SW   = 2'd1;
  localparam logic [1:0] MODE_AUTO = 2'd2;
  localparam logic [1:0] MODE_CW   = 2'd3;

  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Multi-flop synchroniser for one asynchronous input, with a synchronised
// level output and a one-cycle rising-edge pulse.
// Ports:
//   clk      system clock
//   rstn     asynchronous active-low reset
//   i_async  asynchronous input
//   o_level  synchronised level (SYNC_STAGES cycles of latency)
//   o_rise   single-cycle pulse on a synchronised 0->1 transition
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_level_d;

endmodule

// File: rtl/laser_pulse_sequencer.sv
// laser_pulse_sequencer
// Multi-channel laser pulse timing engine. Generates NUM_CH phase-offset pulse
// trains from one shared period in EXT-trigger, SW-trigger, AUTO free-run or
// CW mode, and forces all outputs low on an EE/OPT shutdown interlock.
//
// Build option: define LASER_SEQ_TRIG_COUNT_EN to build the 16-bit accepted
// trigger counter; without it trig_count is tied to zero.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   enable               master run enable
//   mode                 MODE_EXT / MODE_SW / MODE_AUTO / MODE_CW
//   trigger              asynchronous external trigger (rising edge)
//   sw_trigger           synchronous single-cycle software trigger
//   ch_enable            per-channel enable
//   period, pulse_width  period and common pulse width in clk cycles
//   ch_delay             per-channel delay, channel i at [i*CNT_W +: CNT_W]
//   cfg_update           loads period/pulse_width/ch_delay into shadow regs
//   ee_shutdown          asynchronous interlock, active high
//   opt_shutdown         asynchronous interlock, active high
//   fault_clear          fault release strobe
//   pulse_out            registered pulse outputs
//   period_active        high while a period runs
//   laser_on             registered OR of pulse_out
//   fault                sticky interlock fault
//   trig_count           accepted start count
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | disabled, outputs low, shadow config loads directly
// ARMED | waiting for a start; in CW pulse_out follows ch_enable
// RUN   | cnt sweeps 0..period-1, channel compares drive the pulses
// FAULT | interlock tripped, outputs forced low until fault_clear
module laser_pulse_sequencer
  import laser_seq_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    trigger,
  input  logic                    sw_trigger,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [CNT_W-1:0]        period,
  input  logic [CNT_W-1:0]        pulse_width,
  input  logic [NUM_CH*CNT_W-1:0] ch_delay,
  input  logic                    cfg_update,
  input  logic                    ee_shutdown,
  input  logic                    opt_shutdown,
  input  logic                    fault_clear,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic                    period_active,
  output logic                    laser_on,
  output logic                    fault,
  output logic [15:0]             trig_count
);

  seq_state_t              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_period;
  logic [CNT_W-1:0]        r_width;
  logic [NUM_CH*CNT_W-1:0] r_delay;
  logic                    r_cfg_pend;
  logic [NUM_CH-1:0]       r_hit;
  logic [NUM_CH-1:0]       r_pulse;
  logic                    r_laser;
  logic                    r_active;
  logic                    r_fault;

  logic w_trig_lvl, w_trig_rise;
  logic w_ee_lvl, w_ee_rise;
  logic w_opt_lvl, w_opt_rise;
  logic w_shut;
  logic w_wrap;
  logic w_cfg_load;
  logic [CNT_W-1:0] w_period_next;
  logic w_start_req;
  logic w_start;
  logic w_restart;
  logic [NUM_CH-1:0] w_hit;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trig (
    .clk(clk), .rstn(rstn), .i_async(trigger), .o_level(w_trig_lvl), .o_rise(w_trig_rise)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ee (
    .clk(clk), .rstn(rstn), .i_async(ee_shutdown), .o_level(w_ee_lvl), .o_rise(w_ee_rise)
  );
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_opt (
    .clk(clk), .rstn(rstn), .i_async(opt_shutdown), .o_level(w_opt_lvl), .o_rise(w_opt_rise)
  );

  // Synchroniser outputs this block does not need; gathered so they read as intentional.
  logic w_unused_sync;
  assign w_unused_sync = &{1'b0, w_trig_lvl, w_ee_rise, w_opt_rise};

  assign w_shut = w_ee_lvl | w_opt_lvl;
  assign w_wrap = (r_state == RUN) && (r_cnt == r_period - CNT_W'(1));

  // Shadow config changes only between periods so a running period never
  // sees a mixed old/new setting; a mid-period strobe waits in r_cfg_pend.
  assign w_cfg_load = (cfg_update | r_cfg_pend) & ~w_shut &
                      ((r_state == IDLE) || (r_state == ARMED) || (w_wrap && enable));
  assign w_period_next = w_cfg_load ? period : r_period;

  always_comb begin
    w_start_req = 1'b0;
    case (mode)
      MODE_EXT:  w_start_req = w_trig_rise;
      MODE_SW:   w_start_req = sw_trigger;
      MODE_AUTO: w_start_req = 1'b1;
      default:   w_start_req = 1'b0;
    endcase
  end

  assign w_start   = (r_state == ARMED) && w_start_req && (r_period != '0);
  // AUTO restarts back-to-back using the period that takes effect at the wrap.
  assign w_restart = w_wrap && (mode == MODE_AUTO) && (w_period_next != '0);

  // Compare in CNT_W+1 bits so delay+width cannot wrap into a false hit;
  // cnt never reaches period, which truncates pulses at the period end.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i] = ch_enable[i] &&
                 ({1'b0, r_cnt} >= {1'b0, r_delay[i*CNT_W +: CNT_W]}) &&
                 ({1'b0, r_cnt} < ({1'b0, r_delay[i*CNT_W +: CNT_W]} + {1'b0, r_width}));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_period   <= '0;
      r_width    <= '0;
      r_delay    <= '0;
      r_cfg_pend <= 1'b0;
      r_hit      <= '0;
      r_pulse    <= '0;
      r_laser    <= 1'b0;
      r_active   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      if (w_cfg_load) begin
        r_period   <= period;
        r_width    <= pulse_width;
        r_delay    <= ch_delay;
        r_cfg_pend <= 1'b0;
      end else if (cfg_update) begin
        r_cfg_pend <= 1'b1;
      end

      if (w_shut) begin
        r_state  <= FAULT;
        r_fault  <= 1'b1;
        r_cnt    <= '0;
        r_hit    <= '0;
        r_pulse  <= '0;
        r_laser  <= 1'b0;
        r_active <= 1'b0;
      end else if ((r_state != FAULT) && !enable) begin
        r_state  <= IDLE;
        r_cnt    <= '0;
        r_hit    <= '0;
        r_pulse  <= '0;
        r_laser  <= 1'b0;
        r_active <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= ARMED;
            r_cnt    <= '0;
            r_hit    <= '0;
            r_pulse  <= '0;
            r_laser  <= 1'b0;
            r_active <= 1'b0;
          end
          ARMED: begin
            r_hit   <= (mode == MODE_CW) ? ch_enable : '0;
            r_pulse <= r_hit;
            r_laser <= |r_pulse;
            r_cnt   <= '0;
            if (w_start) begin
              r_state  <= RUN;
              r_active <= 1'b1;
            end
          end
          RUN: begin
            r_hit   <= w_hit;
            r_pulse <= r_hit;
            r_laser <= |r_pulse;
            if (w_wrap) begin
              r_cnt <= '0;
              if (!w_restart) begin
                r_state  <= ARMED;
                r_active <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          FAULT: begin
            r_cnt    <= '0;
            r_hit    <= '0;
            r_pulse  <= '0;
            r_laser  <= 1'b0;
            r_active <= 1'b0;
            if (fault_clear) begin
              r_state <= IDLE;
              r_fault <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign pulse_out     = r_pulse;
  assign period_active = r_active;
  assign laser_on      = r_laser;
  assign fault         = r_fault;

`ifdef LASER_SEQ_TRIG_COUNT_EN
  logic        w_accept;
  logic [15:0] r_trig_count;

  assign w_accept = ~w_shut & enable & (w_start | w_restart);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_trig_count <= 16'h0000;
    end else if (w_accept) begin
      r_trig_count <= r_trig_count + 16'd1;
    end
  end

  assign trig_count = r_trig_count;
`else
  assign trig_count = 16'h0000;
`endif

endmodule

// File: doc/laser_pulse_sequencer.md
# laser_pulse_sequencer

Multi-channel laser pulse timing engine and the parametrised successor to the single-channel pulse/period generator in the TA driver path. It sits between the I2C register file and the laser driver/DAC blocks. It generates NUM_CH phase-offset pulse trains from one shared period in external-trigger, software-trigger, free-run or CW mode, and forces every output low on an EE/OPT shutdown interlock.

## Interface
Parameters:
- NUM_CH, 2, number of pulse output channels (1..8)
- CNT_W, 24, width of the period, width and delay counters
- SYNC_STAGES, 2, synchroniser depth for asynchronous inputs (>=2)

Ports:
- clk  in  1  system clock (25 MHz); one clock; all logic on the rising edge
- rstn  in  1  asynchronous, active-low reset
- enable  in  1  master run enable
- mode  in  2  0 = EXT trigger, 1 = SW trigger, 2 = AUTO free-run, 3 = CW
- trigger  in  1  external trigger, asynchronous, rising-edge active
- sw_trigger  in  1  single-cycle software trigger, synchronous
- ch_enable  in  NUM_CH  per-channel enable
- period  in  CNT_W  period length in clk cycles
- pulse_width  in  CNT_W  pulse high time in clk cycles, common to all channels
- ch_delay  in  NUM_CH*CNT_W  per-channel delay from period start; channel i uses bits [i*CNT_W +: CNT_W]
- cfg_update  in  1  strobe that loads period, pulse_width and ch_delay into shadow registers
- ee_shutdown, opt_shutdown  in  1 each  asynchronous interlocks, active high
- fault_clear  in  1  synchronous fault-release strobe
- pulse_out  out  NUM_CH  registered pulse outputs
- period_active  out  1  high while a period is running
- laser_on  out  1  registered OR of pulse_out
- fault  out  1  sticky interlock fault
- trig_count  out  16  count of accepted triggers

## Operation
- States: IDLE, ARMED, RUN, FAULT. Reset value is IDLE. All outputs reset to 0.
- IDLE -> ARMED when enable=1 and no fault condition is present.
- ARMED -> RUN on an accepted start:
  - EXT: synchronised rising edge of trigger.
  - SW: sw_trigger.
  - AUTO: starts immediately.
  - CW: does not use RUN. All pulse_out follow ch_enable while ARMED.
- A start is rejected, and the block stays ARMED, when shadow period == 0.
- RUN: counter cnt counts 0..period-1.
  - Channel i output is high when ch_enable[i]=1 and d_i <= cnt < d_i + pulse_width.
  - The compare is done in CNT_W+1 bits, so no wrap occurs. A pulse that extends past period-1 is truncated at the period end.
  - pulse_width == 0 gives no pulse. d_i >= period gives no pulse.
- End of period: AUTO restarts at cnt=0 with no gap. EXT and SW return to ARMED.
- Triggers received during RUN are ignored and are not counted.
- Shadow registers load on cfg_update only in IDLE or ARMED, or on the cycle cnt wraps. A cfg_update at any other time is held pending and applied at the next period end.
- enable falling: the block goes to IDLE on the next cycle, cnt clears, and all outputs go low. The current period is aborted.
- Either synchronised shutdown asserted, from any state, sends the block to FAULT:
  - fault=1, and pulse_out, laser_on and period_active go to 0.
- FAULT -> IDLE only on fault_clear while both synchronised shutdowns are low. Otherwise fault_clear is ignored.
- Shutdown has priority over trigger, enable and cfg_update when they occur in the same cycle.
- trig_count increments on each accepted start, including every AUTO restart. It wraps at 0xFFFF and clears only on reset.

## Timing
- EXT trigger to output: a channel with delay 0 raises pulse_out SYNC_STAGES+2 clk after the first clk edge that samples trigger high. A delay d adds exactly d cycles.
- SW trigger to output: sw_trigger high at edge N gives pulse_out high at edge N+2.
- Pulse shape: pulse_out is high for exactly min(pulse_width, period-d) cycles.
- AUTO repetition: rising edges are exactly period cycles apart.
- period_active rises and falls with the RUN state.
- laser_on lags pulse_out by 1 cycle.
- Shutdown to safe outputs: outputs are low within SYNC_STAGES+1 cycles of shutdown assertion.

## Configuration
- LASER_SEQ_TRIG_COUNT_EN:
  - Defined: the 16-bit trig_count counter is built as described above.
  - Undefined: the counter is removed and trig_count is tied to 16'h0000. All other behaviour is unchanged.

## Structure
- Package laser_seq_pkg holds:
  - the mode encodings MODE_EXT, MODE_SW, MODE_AUTO, MODE_CW;
  - the state enum (IDLE, ARMED, RUN, FAULT);
  - the default SYNC_STAGES.
- Sub-module sync_edge_detect is parametrised by SYNC_STAGES. It provides a synchroniser with level and rising-edge outputs, and is instanced for trigger, ee_shutdown and opt_shutdown.

## Test plan
- AUTO, NUM_CH=2, period=10, width=3, delays 0 and 5 -> ch0 high at cnt 0-2 and ch1 high at cnt 5-7, each period; rising edges exactly 10 cycles apart; trig_count increments by 1 per period.
- EXT, period=20, width=4, delay 0, trigger pulse -> pulse_out high SYNC_STAGES+2 cycles later for 4 cycles; a second trigger at cnt=10 is ignored and not counted.
- Boundary: period=8, width=6, delay=5 -> pulse truncated to 3 cycles; width=0 -> no pulse; period=0 with sw_trigger -> block stays ARMED and trig_count is unchanged.
- ee_shutdown asserted mid-pulse -> all outputs 0 within SYNC_STAGES+1 cycles and fault=1; fault_clear while shutdown is still high -> ignored; fault_clear after release -> IDLE.
- cfg_update during RUN changing period 10 -> 16 -> current period completes at 10, the next period is 16.
- rstn low mid-RUN -> all outputs 0 immediately; block is in IDLE after reset release; trig_count is 0.
